rx_fifo_writer: RTL and testbench



---
 rtl/rx_fifo_writer.sv | 195 +++++++++++++++++++
 tb/tb_rx_fifo_writer.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_fifo_writer.sv
// Receive stage ahead of the RX FIFO: buffers N-chars, drives the FIFO's three-cycle write
// handshake, schedules FCTs and tracks receive credit. Option macro: RX_FIFO_WRITER_CREDIT_CHECK_EN.
module rx_fifo_writer #(
    parameter int DWIDTH      = 9,
    parameter int BUF_AWIDTH  = 2,
    parameter int CREDIT_MAX  = 56,
    parameter int CREDIT_STEP = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              link_run,
    input  logic              rx_char_valid,
    input  logic [DWIDTH-1:0] rx_char,
    input  logic              fifo_full,
    input  logic              fifo_open_slot,
    output logic              fifo_wr_en,
    output logic [DWIDTH-1:0] fifo_data,
    output logic              fct_req,
    input  logic              fct_ack,
    output logic [5:0]        credit,
    output logic              credit_error,
    output logic              buf_overflow
);

    // state     | meaning
    // ST_IDLE   | waiting for a buffered char and room in the FIFO
    // ST_STROBE | fifo_wr_en high for exactly one cycle
    // ST_HOLD   | write enable released, fifo_data held
    // ST_PTR    | FIFO pointer update; may chain straight into the next write
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STROBE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_PTR    = 2'd3;

    localparam int                  DEPTH        = 1 << BUF_AWIDTH;
    localparam logic [BUF_AWIDTH:0] DEPTH_CNT    = (BUF_AWIDTH+1)'(DEPTH);
    localparam logic [BUF_AWIDTH:0] CNT_ONE      = (BUF_AWIDTH+1)'(1);
    localparam logic [BUF_AWIDTH-1:0] PTR_ONE    = (BUF_AWIDTH)'(1);
    localparam logic [2:0]          FCT_INIT     = 3'(CREDIT_MAX / CREDIT_STEP);
    localparam logic [6:0]          CREDIT_LIMIT = 7'(CREDIT_MAX - CREDIT_STEP);
    localparam logic [6:0]          CREDIT_INC   = 7'(CREDIT_STEP);

    logic [DWIDTH-1:0]     buf_mem [DEPTH];
    logic [BUF_AWIDTH-1:0] wr_ptr;
    logic [BUF_AWIDTH-1:0] rd_ptr;
    logic [BUF_AWIDTH:0]   count;
    logic [1:0]            state;
    logic                  link_run_q;
    logic                  open_slot_q;
    logic [2:0]            pending_fct;
    logic [2:0]            pending_nxt;
    logic [6:0]            credit_sum;
    logic [6:0]            credit_nxt;
    logic                  credit_dec;
    logic                  char_in;
    logic                  char_has_credit;
    logic                  char_ok;
    logic                  buf_full;
    logic                  buf_empty;
    logic                  enq;
    logic                  drop;
    logic                  start_wr;
    logic                  ack_ok;
    logic                  link_rise;
    logic                  open_rise;
    logic                  fct_req_nxt;

    assign char_in   = link_run && rx_char_valid;
    assign char_ok   = char_in && char_has_credit;
    assign buf_full  = (count == DEPTH_CNT);
    assign buf_empty = (count == '0);
    assign enq       = char_ok && !buf_full;
    assign drop      = char_ok && buf_full;
    assign start_wr  = link_run && !buf_empty && !fifo_full &&
                       ((state == ST_IDLE) || (state == ST_PTR));

    assign link_rise = link_run && !link_run_q;
    assign open_rise = link_run && fifo_open_slot && !open_slot_q;
    assign ack_ok    = link_run && fct_ack && fct_req && (pending_fct != 3'd0) &&
                       ({1'b0, credit} <= CREDIT_LIMIT);

    // Without credit checking the count still tracks but clamps at zero instead of underflowing.
    assign credit_sum  = {1'b0, credit} + (ack_ok ? CREDIT_INC : 7'd0);
    assign credit_dec  = char_ok && (credit_sum != 7'd0);
    assign credit_nxt  = credit_sum - {6'd0, credit_dec};

    always_comb begin
        pending_nxt = pending_fct;
        if (ack_ok)
            pending_nxt = pending_nxt - 3'd1;
        if (open_rise && (pending_nxt != 3'd7))
            pending_nxt = pending_nxt + 3'd1;
        if (link_rise)
            pending_nxt = FCT_INIT;
    end

    assign fct_req_nxt = link_run && (pending_nxt != 3'd0) && (credit_nxt <= CREDIT_LIMIT);

`ifdef RX_FIFO_WRITER_CREDIT_CHECK_EN
    logic credit_error_q;

    assign char_has_credit = (credit != 6'd0);
    assign credit_error    = credit_error_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            credit_error_q <= 1'b0;
        else if (!link_run)
            credit_error_q <= 1'b0;
        else if (char_in && !char_has_credit)
            credit_error_q <= 1'b1;
    end
`else
    assign char_has_credit = 1'b1;
    assign credit_error    = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            link_run_q  <= 1'b0;
            open_slot_q <= 1'b0;
            pending_fct <= 3'd0;
            credit      <= 6'd0;
            fct_req     <= 1'b0;
        end else begin
            link_run_q  <= link_run;
            open_slot_q <= fifo_open_slot;
            if (!link_run) begin
                pending_fct <= 3'd0;
                credit      <= 6'd0;
                fct_req     <= 1'b0;
            end else begin
                pending_fct <= pending_nxt;
                credit      <= credit_nxt[5:0];
                fct_req     <= fct_req_nxt;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (enq)
            buf_mem[wr_ptr] <= rx_char;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            buf_overflow <= 1'b0;
        end else if (!link_run) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            buf_overflow <= 1'b0;
        end else begin
            if (enq)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (start_wr)
                rd_ptr <= rd_ptr + PTR_ONE;
            if (enq && !start_wr)
                count <= count + CNT_ONE;
            else if (!enq && start_wr)
                count <= count - CNT_ONE;
            if (drop)
                buf_overflow <= 1'b1;
        end
    end

    // The handshake runs to completion regardless of link_run so FIFO pointers stay coherent.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            fifo_wr_en <= 1'b0;
            fifo_data  <= '0;
        end else begin
            fifo_wr_en <= 1'b0;
            case (state)
                ST_IDLE, ST_PTR: begin
                    if (start_wr) begin
                        state      <= ST_STROBE;
                        fifo_wr_en <= 1'b1;
                        fifo_data  <= buf_mem[rd_ptr];
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_STROBE: state <= ST_HOLD;
                ST_HOLD:   state <= ST_PTR;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_fifo_writer.sv
// Self-checking bench for rx_fifo_writer: directed scenarios plus a randomized phase
// scored against a credit/FCT reference model and a queue of expected FIFO writes.
module tb_rx_fifo_writer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       link_run = 1'b0;
    logic       rx_char_valid = 1'b0;
    logic [8:0] rx_char = 9'd0;
    logic       fifo_full = 1'b0;
    logic       fifo_open_slot = 1'b0;
    logic       fct_ack = 1'b0;
    logic       fifo_wr_en;
    logic [8:0] fifo_data;
    logic       fct_req;
    logic [5:0] credit;
    logic       credit_error;
    logic       buf_overflow;

    int errors = 0;
    int checks = 0;

    int  m_credit = 0;
    int  m_pending = 0;
    bit  m_fct_req = 1'b0;
    bit  m_cerr = 1'b0;
    bit  m_link_q = 1'b0;
    bit  m_open_q = 1'b0;
    bit  rnd_phase = 1'b0;
    logic [8:0] exp_q [$];

`ifdef RX_FIFO_WRITER_CREDIT_CHECK_EN
    localparam int CZ_WRITES = 0;
    localparam int CZ_ERROR  = 1;
`else
    localparam int CZ_WRITES = 1;
    localparam int CZ_ERROR  = 0;
`endif

    rx_fifo_writer dut (
        .clock          (clock),
        .reset          (reset),
        .link_run       (link_run),
        .rx_char_valid  (rx_char_valid),
        .rx_char        (rx_char),
        .fifo_full      (fifo_full),
        .fifo_open_slot (fifo_open_slot),
        .fifo_wr_en     (fifo_wr_en),
        .fifo_data      (fifo_data),
        .fct_req        (fct_req),
        .fct_ack        (fct_ack),
        .credit         (credit),
        .credit_error   (credit_error),
        .buf_overflow   (buf_overflow)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit has_credit(int cr);
`ifdef RX_FIFO_WRITER_CREDIT_CHECK_EN
        return cr != 0;
`else
        return 1'b1;
`endif
    endfunction

    function automatic int next_credit(int cr, bit ack, bit valid);
        int v = cr + (ack ? 8 : 0);
        if (valid && has_credit(cr) && v > 0)
            v = v - 1;
        return v;
    endfunction

    function automatic int next_pending(int pd, bit ack, bit link_rise, bit open_rise);
        int v = pd - (ack ? 1 : 0);
        if (open_rise && v < 7)
            v = v + 1;
        if (link_rise)
            v = 7;
        return v;
    endfunction

    // Reference model: credit, FCT bookkeeping and the ordered stream of chars that must reach the FIFO.
    always @(posedge clock) begin
        if (!reset) begin
            m_credit  <= 0;
            m_pending <= 0;
            m_fct_req <= 1'b0;
            m_cerr    <= 1'b0;
            m_link_q  <= 1'b0;
            m_open_q  <= 1'b0;
        end else begin
            m_link_q <= link_run;
            m_open_q <= fifo_open_slot;
            if (!link_run) begin
                m_credit  <= 0;
                m_pending <= 0;
                m_fct_req <= 1'b0;
                m_cerr    <= 1'b0;
            end else begin
                m_credit  <= next_credit(m_credit, fct_ack && m_fct_req, rx_char_valid);
                m_pending <= next_pending(m_pending, fct_ack && m_fct_req, !m_link_q,
                                          fifo_open_slot && !m_open_q);
                m_fct_req <= (next_pending(m_pending, fct_ack && m_fct_req, !m_link_q,
                                           fifo_open_slot && !m_open_q) != 0) &&
                             (next_credit(m_credit, fct_ack && m_fct_req, rx_char_valid) <= 48);
                if (rx_char_valid && !has_credit(m_credit))
                    m_cerr <= 1'b1;
                if (rnd_phase && rx_char_valid && has_credit(m_credit))
                    exp_q.push_back(rx_char);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        chk("credit_model", 32'(credit), 32'(m_credit));
        chk("fct_req_model", 32'(fct_req), 32'(m_fct_req));
        chk("credit_error_model", 32'(credit_error), 32'(m_cerr));
        if (rnd_phase && fifo_wr_en) begin
            chk("sb_pending", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0)
                chk("sb_data", 32'(fifo_data), 32'(exp_q.pop_front()));
        end
    endtask

    initial begin
        logic [8:0] td [3];
        logic [8:0] d [5];
        logic [8:0] la [3];
        int wr_k [4];
        logic [8:0] wr_d [4];
        int n;
        int since;

        td = '{9'h041, 9'h042, 9'h100};

        // reset state
        repeat (2) tick();
        chk("rst_wr_en", 32'(fifo_wr_en), 32'd0);
        chk("rst_data", 32'(fifo_data), 32'd0);
        chk("rst_fct_req", 32'(fct_req), 32'd0);
        chk("rst_credit", 32'(credit), 32'd0);
        chk("rst_credit_error", 32'(credit_error), 32'd0);
        chk("rst_overflow", 32'(buf_overflow), 32'd0);

        // link up, seven FCTs
        reset = 1'b1;
        tick();
        link_run = 1'b1;
        tick();
        chk("fct_req_rise", 32'(fct_req), 32'd1);
        chk("credit_start", 32'(credit), 32'd0);
        for (int i = 0; i < 7; i++) begin
            fct_ack = 1'b1;
            tick();
            fct_ack = 1'b0;
            chk("credit_after_ack", 32'(credit), 32'(8 * (i + 1)));
        end
        chk("fct_req_done", 32'(fct_req), 32'd0);
        fct_ack = 1'b1;
        tick();
        fct_ack = 1'b0;
        chk("ack_ignored", 32'(credit), 32'd56);

        // latency and 3-cycle write handshake
        for (int k = 0; k < 10; k++) begin
            rx_char_valid = (k % 3 == 0) && (k < 9);
            rx_char = td[k / 3];
            tick();
            rx_char_valid = 1'b0;
            chk("lat_wr_en", 32'(fifo_wr_en), 32'(k % 3 == 1));
            if (k >= 1)
                chk("lat_data", 32'(fifo_data), 32'(td[(k - 1) / 3]));
        end
        chk("lat_credit", 32'(credit), 32'd53);

        // buffer overflow with FIFO full, then drain
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            d[i] = 9'($urandom);
            rx_char_valid = 1'b1;
            rx_char = d[i];
            tick();
            chk("ovf_flag", 32'(buf_overflow), 32'(i == 4));
            chk("ovf_no_wr", 32'(fifo_wr_en), 32'd0);
        end
        rx_char_valid = 1'b0;
        repeat (3) begin
            tick();
            chk("full_stall", 32'(fifo_wr_en), 32'd0);
        end
        fifo_full = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            wr_k[i] = -100;
            wr_d[i] = 9'h1ff;
        end
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (fifo_wr_en) begin
                if (n < 4) begin
                    wr_k[n] = k;
                    wr_d[n] = fifo_data;
                end
                n++;
            end
        end
        chk("ovf_wr_count", 32'(n), 32'd4);
        chk("ovf_first_wr", 32'(wr_k[0]), 32'd1);
        for (int i = 0; i < 4; i++) begin
            chk("ovf_wr_data", 32'(wr_d[i]), 32'(d[i]));
            if (i > 0)
                chk("ovf_wr_gap", 32'(wr_k[i] - wr_k[i-1]), 32'd3);
        end
        chk("ovf_credit", 32'(credit), 32'd48);

        // char arriving with zero credit
        link_run = 1'b0;
        tick();
        chk("ldown_credit", 32'(credit), 32'd0);
        chk("ldown_overflow", 32'(buf_overflow), 32'd0);
        chk("ldown_fct_req", 32'(fct_req), 32'd0);
        link_run = 1'b1;
        tick();
        chk("lup_fct_req", 32'(fct_req), 32'd1);
        rx_char_valid = 1'b1;
        rx_char = 9'h0aa;
        tick();
        rx_char_valid = 1'b0;
        chk("cz_credit", 32'(credit), 32'd0);
        chk("cz_error", 32'(credit_error), 32'(CZ_ERROR));
        n = 0;
        repeat (5) begin
            tick();
            if (fifo_wr_en)
                n++;
        end
        chk("cz_writes", 32'(n), 32'(CZ_WRITES));

        // fct_ack and char in the same cycle at credit 10
        fct_ack = 1'b1;
        tick();
        tick();
        fct_ack = 1'b0;
        chk("two_acks", 32'(credit), 32'd16);
        for (int i = 0; i < 6; i++) begin
            rx_char_valid = 1'b1;
            rx_char = 9'($urandom);
            tick();
            rx_char_valid = 1'b0;
            tick();
            tick();
        end
        chk("pre_combo_credit", 32'(credit), 32'd10);
        repeat (4) tick();
        fct_ack = 1'b1;
        rx_char_valid = 1'b1;
        rx_char = 9'h155;
        tick();
        fct_ack = 1'b0;
        rx_char_valid = 1'b0;
        chk("ack_and_char", 32'(credit), 32'd17);
        chk("combo_fct_req", 32'(fct_req), 32'd1);
        repeat (4) tick();

        // link_run falls while in STROBE
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            la[i] = 9'($urandom);
            rx_char_valid = 1'b1;
            rx_char = la[i];
            tick();
        end
        rx_char_valid = 1'b0;
        tick();
        fifo_full = 1'b0;
        tick();
        chk("lf_strobe", 32'(fifo_wr_en), 32'd1);
        chk("lf_data", 32'(fifo_data), 32'(la[0]));
        link_run = 1'b0;
        tick();
        chk("lf_hold_en", 32'(fifo_wr_en), 32'd0);
        chk("lf_hold_data", 32'(fifo_data), 32'(la[0]));
        chk("lf_credit", 32'(credit), 32'd0);
        chk("lf_fct_req", 32'(fct_req), 32'd0);
        chk("lf_credit_error", 32'(credit_error), 32'd0);
        chk("lf_overflow", 32'(buf_overflow), 32'd0);
        tick();
        chk("lf_ptr_en", 32'(fifo_wr_en), 32'd0);
        chk("lf_ptr_data", 32'(fifo_data), 32'(la[0]));
        n = 0;
        repeat (6) begin
            tick();
            if (fifo_wr_en)
                n++;
        end
        link_run = 1'b1;
        repeat (6) begin
            tick();
            if (fifo_wr_en)
                n++;
        end
        chk("lf_flushed", 32'(n), 32'd0);
        chk("lf_relink_fct_req", 32'(fct_req), 32'd1);

        // randomized traffic: chars at least 3 cycles apart, random acks and open-slot edges
        rnd_phase = 1'b1;
        since = 3;
        for (int i = 0; i < 400; i++) begin
            since++;
            if (since >= 3 && $urandom_range(0, 1) == 1) begin
                rx_char_valid = 1'b1;
                rx_char = 9'($urandom);
                since = 0;
            end
            fct_ack = ($urandom_range(0, 2) == 0);
            fifo_open_slot = ($urandom_range(0, 1) == 1);
            tick();
            rx_char_valid = 1'b0;
            fct_ack = 1'b0;
        end
        fifo_open_slot = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("rnd_overflow", 32'(buf_overflow), 32'd0);
        rnd_phase = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
